// File: rtl/ram8_word16_if.sv
// Bus interface for the 8-word register-file RAM.
// The master drives write data, load and address; the slave returns read data.
interface ram8_word16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic [2:0]       address;
    logic [WIDTH-1:0] out;

    modport master (
        output in,
        output load,
        output address,
        input  out
    );

    modport slave (
        input  in,
        input  load,
        input  address,
        output out
    );
endinterface

// File: rtl/ram8_word16.sv
// ram8_word16: 8 x WIDTH register-file RAM tile.
// Synchronous write on the rising clk edge when load is high.
// Combinational read of word[address].
// Asynchronous active-high reset clears every word.
// Optional macro RAM8_WR_BYPASS_EN: while load=1 and rst=0, out follows in
// combinationally regardless of address; storage timing is unchanged.
module ram8_word16 #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    ram8_word16_if.slave  bus
);

    localparam int DEPTH = 8;

    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] word_d [DEPTH];
    logic [WIDTH-1:0] rd_data;

    // Next-state of the storage: only the addressed word takes the write data.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            word_d[i] = word_q[i];
        end
        if (bus.load) begin
            word_d[bus.address] = bus.in;
        end
    end

    // Storage registers; reset clears all words and blocks any write on a coincident edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

    // Read path: the addressed word, optionally overridden by the incoming write data.
    always_comb begin
        rd_data = word_q[bus.address];
`ifdef RAM8_WR_BYPASS_EN
        if (bus.load && !rst) begin
            rd_data = bus.in;
        end
`endif
    end

    assign bus.out = rd_data;

endmodule

// File: tb/tb_ram8_word16.sv
// Directed self-checking bench for ram8_word16.
module tb_ram8_word16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ram8_word16_if #(.WIDTH(16)) bus ();

    ram8_word16 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst         = 1'b1;
        bus.load    = 1'b0;
        bus.in      = 16'h0000;
        bus.address = 3'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check("reset_out", bus.out, 16'h0000);
        rst = 1'b0;

        // Preload word[3] = BEEF
        @(negedge clk);
        bus.address = 3'd3;
        bus.in      = 16'hBEEF;
        bus.load    = 1'b1;
        @(posedge clk);
        #1 check("preload_w3", bus.out, 16'hBEEF);
        @(negedge clk);
        bus.load = 1'b0;
        #1 check("preload_hold", bus.out, 16'hBEEF);

        // Async reset between edges clears immediately
        rst = 1'b1;
        #1 check("async_rst_out", bus.out, 16'h0000);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = a[2:0];
            #1 check("post_rst_sweep", bus.out, 16'h0000);
        end

        // Sequential fill: word[i] = i<<12
        @(negedge clk);
        bus.load = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus.address = a[2:0];
            bus.in      = 16'(a) << 12;
            @(posedge clk);
            #1 check("fill_write", bus.out, 16'(a) << 12);
            @(negedge clk);
        end
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = a[2:0];
            #1 check("fill_sweep", bus.out, 16'(a) << 12);
        end

        // Load low holds word[5]
        @(negedge clk);
        bus.address = 3'd5;
        bus.in      = 16'hFFFF;
        bus.load    = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("load_low_w5", bus.out, 16'h5000);

        // Isolation: write A5A5 to address 2
        @(negedge clk);
        bus.address = 3'd2;
        bus.in      = 16'hA5A5;
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.load    = 1'b0;
        bus.address = 3'd1;
        #1 check("iso_w1", bus.out, 16'h1000);
        bus.address = 3'd3;
        #1 check("iso_w3", bus.out, 16'h3000);
        bus.address = 3'd2;
        #1 check("iso_w2", bus.out, 16'hA5A5);

        // Overwrite address 2: read-during-write before and after the edge
        @(negedge clk);
        bus.in   = 16'h5A5A;
        bus.load = 1'b1;
`ifdef RAM8_WR_BYPASS_EN
        #1 check("rdw_before", bus.out, 16'h5A5A);
`else
        #1 check("rdw_before", bus.out, 16'hA5A5);
`endif
        @(posedge clk);
        #1 check("rdw_after", bus.out, 16'h5A5A);
        @(negedge clk);
        bus.load = 1'b0;
        bus.address = 3'd1;
        #1 check("iso_w1_again", bus.out, 16'h1000);

        // Reset priority: edge with rst high does not write
        @(negedge clk);
        rst         = 1'b1;
        bus.load    = 1'b1;
        bus.in      = 16'h1234;
        bus.address = 3'd4;
        #1 check("rst_block_out", bus.out, 16'h0000);
        @(posedge clk);
        #1 check("rst_edge_out", bus.out, 16'h0000);
        @(negedge clk);
        bus.load = 1'b0;
        rst      = 1'b0;
        #1 check("rst_prio_w4", bus.out, 16'h0000);
        bus.address = 3'd7;
        #1 check("rst_prio_w7", bus.out, 16'h0000);

        // First edge after release writes normally
        @(negedge clk);
        bus.address = 3'd4;
        bus.in      = 16'h1234;
        bus.load    = 1'b1;
        @(posedge clk);
        #1 check("post_release_wr", bus.out, 16'h1234);
        @(negedge clk);
        bus.load = 1'b0;

        // Prepare word[6] = 6000
        bus.address = 3'd6;
        bus.in      = 16'h6000;
        bus.load    = 1'b1;
        @(posedge clk);
        #1 check("w6_prep", bus.out, 16'h6000);
        @(negedge clk);
        bus.load = 1'b0;

        // Bypass behaviour at address 6
        @(negedge clk);
        bus.in   = 16'hC0DE;
        bus.load = 1'b1;
`ifdef RAM8_WR_BYPASS_EN
        #1 check("bypass_before", bus.out, 16'hC0DE);
`else
        #1 check("bypass_before", bus.out, 16'h6000);
`endif
        @(posedge clk);
        #1 check("bypass_after", bus.out, 16'hC0DE);
        @(negedge clk);
        bus.load    = 1'b0;
        bus.address = 3'd4;
        #1 check("w4_unchanged", bus.out, 16'h1234);
        bus.address = 3'd6;
        #1 check("w6_final", bus.out, 16'hC0DE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
